// File: rtl/ifu_if.sv
// Fetch-to-decode channel: redirect and stall controls from decode, instruction stream back.
// master is the fetch unit side and slave is the decode side.
interface ifu_if #(
  parameter int COUNT_WIDTH = 16
) ();
  logic                   stall;
  logic                   is_jump;
  logic                   is_branch;
  logic                   is_jr;
  logic [15:0]            imm16;
  logic [25:0]            addr26;
  logic [31:0]            jr_target;
  logic [31:0]            instruction;
  logic [31:0]            pc;
  logic                   valid;
  logic [COUNT_WIDTH-1:0] fetch_count;

  modport master (
    input  stall, is_jump, is_branch, is_jr, imm16, addr26, jr_target,
    output instruction, pc, valid, fetch_count
  );

  modport slave (
    output stall, is_jump, is_branch, is_jr, imm16, addr26, jr_target,
    input  instruction, pc, valid, fetch_count
  );
endinterface

// File: rtl/ifu_pipelined.sv
// Pipelined MIPS instruction fetch: PC, synchronous-read instruction memory, zero-bubble
// jump/jr/branch redirects with an optional single branch-delay slot.
module ifu_pipelined #(
  parameter int          IMEM_WORDS  = 256,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DELAY_SLOT  = 0,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  ifu_if.master  bus
);
  localparam int AW = $clog2(IMEM_WORDS);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // No write port: contents are loaded from outside the design.
  logic [31:0] storage [IMEM_WORDS];

  logic [31:0]            instr_reg;
  logic [31:0]            pc_reg;
  logic                   valid_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   pending_reg;
  logic                   pending_next;
  logic [31:0]            pending_target_reg;
  logic [31:0]            pending_target_next;

  logic        accept;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic [31:0] fetch_addr;
  logic [AW-1:0] rd_idx;
  logic        unused_bits;

  always_comb begin
    pc_plus4   = pc_reg + 32'd4;
    branch_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    redirect   = bus.is_jr | bus.is_jump | bus.is_branch;
    if (bus.is_jr)
      target = {bus.jr_target[31:2], 2'b00};
    else if (bus.is_jump)
      target = {pc_plus4[31:28], bus.addr26, 2'b00};
    else
      target = pc_plus4 + branch_off;
  end

  // With a delay slot the redirect is parked for one fetch; a redirect seen
  // while one is already parked belongs to the delay slot and is dropped.
  always_comb begin
    next_pc             = pc_plus4;
    pending_next        = pending_reg;
    pending_target_next = pending_target_reg;
    if (DELAY_SLOT != 0) begin
      if (pending_reg) begin
        next_pc      = pending_target_reg;
        pending_next = 1'b0;
      end else if (redirect) begin
        pending_next        = 1'b1;
        pending_target_next = target;
      end
    end else if (redirect) begin
      next_pc = target;
    end
  end

  assign accept      = valid_reg & ~bus.stall;
  assign fetch_addr  = valid_reg ? next_pc : RESET_PC;
  assign rd_idx      = fetch_addr[AW+1:2];
  assign unused_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0], bus.jr_target[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg          <= 32'h0;
      pc_reg             <= RESET_PC;
      valid_reg          <= 1'b0;
      count_reg          <= '0;
      pending_reg        <= 1'b0;
      pending_target_reg <= 32'h0;
    end else if (!valid_reg) begin
      instr_reg <= storage[rd_idx];
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b1;
    end else if (accept) begin
      instr_reg          <= storage[rd_idx];
      pc_reg             <= next_pc;
      count_reg          <= count_reg + CNT_ONE;
      pending_reg        <= pending_next;
      pending_target_reg <= pending_target_next;
    end
  end

  assign bus.instruction = instr_reg;
  assign bus.pc          = pc_reg;
  assign bus.valid       = valid_reg;
  assign bus.fetch_count = count_reg;
endmodule

// File: tb/tb_ifu_pipelined.sv
// Directed bench for ifu_pipelined: table-driven run without delay slot, hand sequences
// for delay-slot redirects and mid-operation reset.
module tb_ifu_pipelined;
  localparam int CW0 = 3;  // narrow counter on u0 so the wrap is reached

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  ifu_if #(.COUNT_WIDTH(CW0)) b0 ();
  ifu_if #(.COUNT_WIDTH(16))  b1 ();
  ifu_if #(.COUNT_WIDTH(16))  b2 ();

  ifu_pipelined #(.IMEM_WORDS(256), .RESET_PC(32'h0), .DELAY_SLOT(0), .COUNT_WIDTH(CW0))
    u0 (.clk(clk), .reset(rst0), .bus(b0));
  ifu_pipelined #(.IMEM_WORDS(256), .RESET_PC(32'h0), .DELAY_SLOT(1), .COUNT_WIDTH(16))
    u1 (.clk(clk), .reset(rst1), .bus(b1));
  ifu_pipelined #(.IMEM_WORDS(256), .RESET_PC(32'h8), .DELAY_SLOT(1), .COUNT_WIDTH(16))
    u2 (.clk(clk), .reset(rst2), .bus(b2));

  typedef struct {
    string       name;
    logic        stall;
    logic        is_jump;
    logic        is_branch;
    logic        is_jr;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] jr_target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    int          exp_count;
  } vec_t;

  vec_t vecs[16];
  int   nvec;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] W0 = 32'hCA0F3355;
  localparam logic [31:0] W1 = 32'h00330FFF;
  localparam logic [31:0] W2 = 32'h20040008;
  localparam logic [31:0] W3 = 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic s, input logic j, input logic b, input logic r,
                         input logic [15:0] imm, input logic [25:0] a26, input logic [31:0] jt,
                         input logic [31:0] epc, input logic [31:0] ein, input int ecnt);
    vecs[nvec] = '{n, s, j, b, r, imm, a26, jt, epc, ein, ecnt};
    nvec++;
  endtask

  task automatic idle_b1();
    b1.stall = 0; b1.is_jump = 0; b1.is_branch = 0; b1.is_jr = 0;
    b1.imm16 = 0; b1.addr26 = 0; b1.jr_target = 0;
  endtask

  task automatic idle_b2();
    b2.stall = 0; b2.is_jump = 0; b2.is_branch = 0; b2.is_jr = 0;
    b2.imm16 = 0; b2.addr26 = 0; b2.jr_target = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      u0.storage[i] = 32'h0;
      u1.storage[i] = 32'h0;
      u2.storage[i] = 32'h0;
    end
    u0.storage[0] = W0; u0.storage[1] = W1; u0.storage[2] = W2; u0.storage[3] = W3;
    u1.storage[0] = W0; u1.storage[1] = W1; u1.storage[2] = W2; u1.storage[3] = W3;
    u2.storage[0] = W0; u2.storage[1] = W1; u2.storage[2] = W2; u2.storage[3] = W3;

    b0.stall = 0; b0.is_jump = 0; b0.is_branch = 0; b0.is_jr = 0;
    b0.imm16 = 0; b0.addr26 = 0; b0.jr_target = 0;
    idle_b1();
    idle_b2();

    // name, stall, jump, branch, jr, imm16, addr26, jr_target -> pc, instruction, count
    nvec = 0;
    add_vec("startup",     0, 0, 0, 0, 16'h0,    26'h0, 32'h0,         32'h0,         W0,    0);
    add_vec("seq_pc4",     0, 0, 0, 0, 16'h0,    26'h0, 32'h0,         32'h4,         W1,    1);
    add_vec("seq_pc8",     0, 0, 0, 0, 16'h0,    26'h0, 32'h0,         32'h8,         W2,    2);
    add_vec("jump_0",      0, 1, 0, 0, 16'h0,    26'h0, 32'h0,         32'h0,         W0,    3);
    add_vec("jump_2",      0, 1, 0, 0, 16'h0,    26'h2, 32'h0,         32'h8,         W2,    4);
    add_vec("branch_back", 0, 0, 1, 0, 16'hFFFD, 26'h0, 32'h0,         32'h0,         W0,    5);
    add_vec("jr_wins",     0, 0, 1, 1, 16'h0005, 26'h0, 32'h0000000F,  32'hC,         W3,    6);
    add_vec("jump_1",      0, 1, 0, 0, 16'h0,    26'h1, 32'h0,         32'h4,         W1,    7);
    add_vec("stall_a",     1, 1, 0, 0, 16'h0,    26'h3, 32'h0,         32'h4,         W1,    7);
    add_vec("stall_b",     1, 1, 0, 0, 16'h0,    26'h3, 32'h0,         32'h4,         W1,    7);
    add_vec("stall_c",     1, 1, 0, 0, 16'h0,    26'h3, 32'h0,         32'h4,         W1,    7);
    add_vec("after_stall", 0, 1, 0, 0, 16'h0,    26'h3, 32'h0,         32'hC,         W3,    8);
    add_vec("jr_wrap",     0, 0, 0, 1, 16'h0,    26'h0, 32'h00000400,  32'h400,       W0,    9);
    add_vec("branch_fwd",  0, 0, 1, 0, 16'h0001, 26'h0, 32'h0,         32'h408,       W2,    10);
    add_vec("jr_high",     0, 0, 0, 1, 16'h0,    26'h0, 32'hF0000003,  32'hF0000000,  W0,    11);
    add_vec("jump_region", 0, 1, 0, 0, 16'h0,    26'h1, 32'h0,         32'hF0000004,  W1,    12);

    // ---- u0: reset state, then the vector table ----
    step();
    step();
    chk("rst_valid", {31'h0, b0.valid}, 32'h0);
    chk("rst_pc",    b0.pc, 32'h0);
    chk("rst_instr", b0.instruction, 32'h0);
    chk("rst_count", 32'(b0.fetch_count), 32'h0);
    rst0 = 0;
    for (int i = 0; i < nvec; i++) begin
      b0.stall     = vecs[i].stall;
      b0.is_jump   = vecs[i].is_jump;
      b0.is_branch = vecs[i].is_branch;
      b0.is_jr     = vecs[i].is_jr;
      b0.imm16     = vecs[i].imm16;
      b0.addr26    = vecs[i].addr26;
      b0.jr_target = vecs[i].jr_target;
      step();
      chk({vecs[i].name, "_valid"}, {31'h0, b0.valid}, 32'h1);
      chk({vecs[i].name, "_pc"},    b0.pc, vecs[i].exp_pc);
      chk({vecs[i].name, "_instr"}, b0.instruction, vecs[i].exp_instr);
      chk({vecs[i].name, "_count"}, 32'(b0.fetch_count), 32'(vecs[i].exp_count % (1 << CW0)));
      $display("vec %0d %s: pc=%h instr=%h count=%0d", i, vecs[i].name, b0.pc, b0.instruction,
               b0.fetch_count);
    end

    // ---- u1: delay slot, branch inside the slot is ignored ----
    step();
    rst1 = 0;
    step();
    chk("ds_start_pc", b1.pc, 32'h0);
    chk("ds_start_instr", b1.instruction, W0);
    b1.is_jump = 1; b1.addr26 = 26'h3;
    step();
    $display("ds slot: pc=%h instr=%h", b1.pc, b1.instruction);
    chk("ds_slot_pc", b1.pc, 32'h4);
    chk("ds_slot_instr", b1.instruction, W1);
    chk("ds_slot_count", 32'(b1.fetch_count), 32'd1);
    idle_b1();
    b1.is_branch = 1; b1.imm16 = 16'h0000;
    step();
    $display("ds target: pc=%h instr=%h", b1.pc, b1.instruction);
    chk("ds_target_pc", b1.pc, 32'hC);
    chk("ds_target_instr", b1.instruction, W3);
    idle_b1();
    step();
    $display("ds after: pc=%h instr=%h", b1.pc, b1.instruction);
    chk("ds_after_pc", b1.pc, 32'h10);
    chk("ds_after_count", 32'(b1.fetch_count), 32'd3);

    // ---- u2: RESET_PC=8, reset while a redirect is pending ----
    step();
    rst2 = 0;
    step();
    chk("rp_start_pc", b2.pc, 32'h8);
    chk("rp_start_instr", b2.instruction, W2);
    b2.is_jump = 1; b2.addr26 = 26'h0;
    step();
    chk("rp_slot_pc", b2.pc, 32'hC);
    idle_b2();
    rst2 = 1;
    step();
    $display("rp reset: valid=%b pc=%h count=%0d", b2.valid, b2.pc, b2.fetch_count);
    chk("rp_rst_valid", {31'h0, b2.valid}, 32'h0);
    chk("rp_rst_pc", b2.pc, 32'h8);
    chk("rp_rst_count", 32'(b2.fetch_count), 32'h0);
    chk("rp_rst_instr", b2.instruction, 32'h0);
    rst2 = 0;
    step();
    chk("rp_again_pc", b2.pc, 32'h8);
    chk("rp_again_instr", b2.instruction, W2);
    step();
    $display("rp next: pc=%h instr=%h", b2.pc, b2.instruction);
    chk("rp_next_pc", b2.pc, 32'hC);
    chk("rp_next_instr", b2.instruction, W3);
    step();
    chk("rp_seq_pc", b2.pc, 32'h10);
    chk("rp_seq_count", 32'(b2.fetch_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_pipelined.md
Name: ifu_pipelined

Overview:
Parametrised instruction fetch unit for the pipelined MIPS core. It is the successor to the single-cycle IFU.
- Holds the PC and an internal instruction memory with synchronous read.
- Presents one instruction per cycle to decode with a valid/stall handshake.
- Resolves jump, jump-register and branch redirects, with an optional MIPS branch-delay-slot mode and an accepted-instruction counter.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words; power of two, >= 2
RESET_PC, 32'h0000_0000, PC of the first instruction fetched after reset; word aligned
DELAY_SLOT, 0, 0 = redirect applies to the next fetch; 1 = one delay-slot instruction is delivered before the redirect target
COUNT_WIDTH, 16, width of fetch_count

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high
stall  input  1  decode not ready; hold the current instruction
is_jump  input  1  current output instruction is j/jal
is_branch  input  1  current output instruction is a taken branch
is_jr  input  1  current output instruction is jr/jalr
imm16  input  16  branch offset, in words, signed
addr26  input  26  jump target field
jr_target  input  32  register jump target
instruction  output  32  fetched instruction
pc  output  32  address of instruction
valid  output  1  instruction/pc are meaningful
fetch_count  output  COUNT_WIDTH  number of accepted instructions, modulo 2^COUNT_WIDTH

Behaviour:
- Clock is clk. Reset is synchronous, active-high, and has priority over everything else.
- Memory: internal array storage[IMEM_WORDS] of 32-bit words. It has no write port; the bench preloads it hierarchically (IFU.storage) with $readmemb. Index = address[log2(IMEM_WORDS)+1:2], so addresses wrap modulo memory size. Address bits [1:0] are ignored.
- Reset values: valid=0, pc=RESET_PC, instruction=0, fetch_count=0, pending=0, pending_target=0.
- Start-up: on the first edge with reset=0 and valid=0, the unit loads instruction<=storage[RESET_PC] and pc<=RESET_PC, and sets valid<=1. Fetch latency is one cycle from the end of reset.
- accept = valid & ~stall. The redirect inputs are sampled only when accept=1 and are ignored otherwise.
- Stall (valid=1, stall=1): instruction, pc, valid, pending and fetch_count all hold. There is no memory read.
- Redirect targets, computed from pc of the current output instruction:
  - jr: {jr_target[31:2], 2'b00}.
  - jump: {(pc+4)[31:28], addr26, 2'b00}.
  - branch: pc + 4 + (sign-extended imm16 << 2), modulo 2^32.
  - Priority when several are set: jr > jump > branch.
- Next fetch address on accept with DELAY_SLOT=0: the target if any redirect is set, else pc+4.
- Next fetch address on accept with DELAY_SLOT=1:
  - If pending=1, the next address is pending_target and pending clears.
  - Otherwise the next address is pc+4. If a redirect is set, pending<=1 and pending_target<=target.
  - A redirect on an instruction accepted while pending=1 (branch in a delay slot) is ignored.
- On accept: instruction<=storage[next], pc<=next, valid stays 1, fetch_count<=fetch_count+1 (wraps).
- The read-address mux is combinational ahead of the synchronous read, so redirects cost zero bubbles.
- Reset mid-operation clears pending and any in-flight redirect. Start-up then repeats from RESET_PC.
- There are no X outputs after reset.

Test Plan:
Preload storage[0..3] = 32'hCA0F3355, 32'h00330FFF, 32'h20040008, 32'hDEADBEEF; RESET_PC=0 unless stated.
1. Reset for 2 cycles, then release with stall=0. Required: on the first edge valid=1, pc=0, instruction=CA0F3355. Following edges give pc=4 (00330FFF) then pc=8 (20040008), with fetch_count=1, 2.
2. DELAY_SLOT=0, at pc=8 assert is_jump with addr26=0. Required: next edge pc=0, instruction=CA0F3355. Then is_jump with addr26=2 gives pc=8, 20040008. Both jumps have no bubble.
3. At pc=8 assert is_branch with imm16=16'hFFFD. Required: pc=0, CA0F3355. At pc=0, is_branch with is_jr and jr_target=32'h0000000F gives pc=12, DEADBEEF (jr wins, low bits dropped).
4. At pc=4 hold stall=1 for 3 cycles with is_jump and addr26=3. Required: pc=4, instruction=00330FFF and fetch_count unchanged throughout. After stall drops, next edge pc=12, DEADBEEF.
5. DELAY_SLOT=1, at pc=0 assert is_jump with addr26=3, then is_branch in the delay slot. Required: pc=4 (00330FFF) first, then pc=12 (DEADBEEF); the delay-slot branch is ignored.
6. RESET_PC=8, DELAY_SLOT=1: set pending via a jump, then assert reset for 1 cycle. Required: valid=0, fetch_count=0, pc=8. After release: pc=8, 20040008, then pc=12, with no stale redirect.
